axis_packet_dispatcher_mux_n: RTL and testbench

- Parametrised N-channel AXI-Stream packet multiplexer for the data_processing scheduler.
- Merges N source streams (parser, demultiplexer remainder path, future analysers) onto one master stream. Full tvalid/tready/tkeep/tlast/tdest handshaking is supported.
- Grant is locked per packet. Channel selection is either externally commanded (scheduler-driven) or internal round-robin.
- Supports commanded packet drop and has a registered output stage.

---
 rtl/axis_packet_dispatcher_mux_n.sv | 154 +++++++++++++++
 tb/tb_axis_packet_dispatcher_mux_n.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_dispatcher_mux_n.sv
// rtl/axis_packet_dispatcher_mux_n.sv - N-channel AXI-Stream packet multiplexer with per-packet grant lock
//
// Merges CHANNELS slave streams onto one registered master stream. A grant is
// taken in IDLE, either from the sel/sel_valid command (ARB_MODE 0) or by
// round-robin over the valid channels (ARB_MODE 1). The grant is then held until
// the granted channel's tlast beat is accepted. In ARB_MODE 0, sel_drop discards
// the commanded packet instead of forwarding it.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   s_axis_t*                   flattened slave channels, channel i in slice i
//   sel, sel_valid, sel_drop    channel command (ARB_MODE 0 only)
//   m_axis_t*                   registered master stream
//   busy                        a grant is held
//   pkt_count, drop_count       forwarded / dropped packet counters (wrapping)
module axis_packet_dispatcher_mux_n #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_DEST_WIDTH = 9,
    parameter int CHANNELS        = 2,
    parameter int SEL_WIDTH       = $clog2(CHANNELS),
    parameter int ARB_MODE        = 0,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CHANNELS*AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [CHANNELS*AXIS_KEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic [CHANNELS*AXIS_DEST_WIDTH-1:0]  s_axis_tdest,
    input  logic [CHANNELS-1:0]                  s_axis_tvalid,
    output logic [CHANNELS-1:0]                  s_axis_tready,
    input  logic [CHANNELS-1:0]                  s_axis_tlast,
    input  logic [SEL_WIDTH-1:0]                 sel,
    input  logic                                 sel_valid,
    input  logic                                 sel_drop,
    output logic [AXIS_DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]           m_axis_tkeep,
    output logic [AXIS_DEST_WIDTH-1:0]           m_axis_tdest,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast,
    output logic                                 busy,
    output logic [CNT_WIDTH-1:0]                 pkt_count,
    output logic [CNT_WIDTH-1:0]                 drop_count
);

    typedef enum logic [1:0] {IDLE, FORWARD, DROP} state_t;

    // One extra bit so that sel values >= CHANNELS can be recognised.
    localparam logic [SEL_WIDTH:0] CH_LIMIT = (SEL_WIDTH + 1)'(CHANNELS);

    state_t               state, state_next;
    logic [SEL_WIDTH-1:0] grant, grant_next;
    logic [SEL_WIDTH-1:0] rr_ptr, rr_ptr_next;
    logic [SEL_WIDTH-1:0] rr_pick;
    logic                 rr_found;
    logic                 out_ready;
    logic                 s_accept;
    logic                 s_last_g;

    logic [AXIS_DATA_WIDTH-1:0] ch_data [CHANNELS];
    logic [AXIS_KEEP_WIDTH-1:0] ch_keep [CHANNELS];
    logic [AXIS_DEST_WIDTH-1:0] ch_dest [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
        assign ch_data[i] = s_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        assign ch_keep[i] = s_axis_tkeep[i*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
        assign ch_dest[i] = s_axis_tdest[i*AXIS_DEST_WIDTH +: AXIS_DEST_WIDTH];
    end

    // Output register can take a new beat when empty or draining this cycle.
    assign out_ready = !m_axis_tvalid || m_axis_tready;
    assign s_accept  = s_axis_tvalid[grant] &&
                       ((state == FORWARD && out_ready) || state == DROP);
    assign s_last_g  = s_axis_tlast[grant];
    assign busy      = (state != IDLE);

    // Round-robin search starts just after the last winner.
    always_comb begin
        logic [SEL_WIDTH-1:0] idx;
        rr_found = 1'b0;
        rr_pick  = rr_ptr;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = SEL_WIDTH'((int'(rr_ptr) + i) % CHANNELS);
            if (!rr_found && s_axis_tvalid[idx]) begin
                rr_found = 1'b1;
                rr_pick  = idx;
            end
        end
    end

    always_comb begin
        state_next    = state;
        grant_next    = grant;
        rr_ptr_next   = rr_ptr;
        s_axis_tready = '0;
        case (state)
            IDLE: begin
                if (ARB_MODE == 0) begin
                    if (sel_valid && ({1'b0, sel} < CH_LIMIT)) begin
                        grant_next = sel;
                        state_next = sel_drop ? DROP : FORWARD;
                    end
                end else if (rr_found) begin
                    grant_next  = rr_pick;
                    rr_ptr_next = rr_pick;
                    state_next  = FORWARD;
                end
            end
            FORWARD: begin
                s_axis_tready[grant] = out_ready;
                if (s_accept && s_last_g) state_next = IDLE;
            end
            DROP: begin
                s_axis_tready[grant] = 1'b1;
                if (s_accept && s_last_g) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grant         <= '0;
            rr_ptr        <= SEL_WIDTH'(CHANNELS - 1);
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tdest  <= '0;
            pkt_count     <= '0;
            drop_count    <= '0;
        end else begin
            state  <= state_next;
            grant  <= grant_next;
            rr_ptr <= rr_ptr_next;
            if (state == FORWARD && s_accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= s_last_g;
                m_axis_tdata  <= ch_data[grant];
                m_axis_tkeep  <= ch_keep[grant];
                m_axis_tdest  <= ch_dest[grant];
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
                pkt_count <= pkt_count + CNT_WIDTH'(1);
            if (state == DROP && s_accept && s_last_g)
                drop_count <= drop_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_axis_packet_dispatcher_mux_n.sv
// tb/tb_axis_packet_dispatcher_mux_n.sv - scoreboard bench for select-driven and round-robin muxes
module tb_axis_packet_dispatcher_mux_n;

    localparam int DW = 32;
    localparam int KW = 4;
    localparam int TW = 9;
    localparam int C0 = 3;
    localparam int C1 = 4;
    localparam int NP = 5;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [TW-1:0] dest;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // select-driven instance, 3 channels
    logic              rst0 = 1'b1;
    logic [C0*DW-1:0]  s0_tdata = '0;
    logic [C0*KW-1:0]  s0_tkeep = '0;
    logic [C0*TW-1:0]  s0_tdest = '0;
    logic [C0-1:0]     s0_tvalid = '0, s0_tready, s0_tlast = '0;
    logic [1:0]        sel0 = '0;
    logic              sel_valid0 = 1'b0, sel_drop0 = 1'b0;
    logic [DW-1:0]     m0_tdata;
    logic [KW-1:0]     m0_tkeep;
    logic [TW-1:0]     m0_tdest;
    logic              m0_tvalid, m0_tlast, busy0;
    logic              m0_tready = 1'b0;
    logic [31:0]       pkt0, drop0;

    // round-robin instance, 4 channels
    logic              rst1 = 1'b1;
    logic [C1*DW-1:0]  s1_tdata = '0;
    logic [C1*KW-1:0]  s1_tkeep = '0;
    logic [C1*TW-1:0]  s1_tdest = '0;
    logic [C1-1:0]     s1_tvalid = '0, s1_tready, s1_tlast = '0;
    logic [DW-1:0]     m1_tdata;
    logic [KW-1:0]     m1_tkeep;
    logic [TW-1:0]     m1_tdest;
    logic              m1_tvalid, m1_tlast, busy1;
    logic              m1_tready = 1'b0;
    logic [31:0]       pkt1, drop1;

    axis_packet_dispatcher_mux_n #(
        .AXIS_DATA_WIDTH(DW), .AXIS_DEST_WIDTH(TW), .CHANNELS(C0), .ARB_MODE(0)
    ) u_sel (
        .clk(clk), .rst(rst0),
        .s_axis_tdata(s0_tdata), .s_axis_tkeep(s0_tkeep), .s_axis_tdest(s0_tdest),
        .s_axis_tvalid(s0_tvalid), .s_axis_tready(s0_tready), .s_axis_tlast(s0_tlast),
        .sel(sel0), .sel_valid(sel_valid0), .sel_drop(sel_drop0),
        .m_axis_tdata(m0_tdata), .m_axis_tkeep(m0_tkeep), .m_axis_tdest(m0_tdest),
        .m_axis_tvalid(m0_tvalid), .m_axis_tready(m0_tready), .m_axis_tlast(m0_tlast),
        .busy(busy0), .pkt_count(pkt0), .drop_count(drop0)
    );

    axis_packet_dispatcher_mux_n #(
        .AXIS_DATA_WIDTH(DW), .AXIS_DEST_WIDTH(TW), .CHANNELS(C1), .ARB_MODE(1)
    ) u_rr (
        .clk(clk), .rst(rst1),
        .s_axis_tdata(s1_tdata), .s_axis_tkeep(s1_tkeep), .s_axis_tdest(s1_tdest),
        .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready), .s_axis_tlast(s1_tlast),
        .sel(2'd0), .sel_valid(1'b1), .sel_drop(1'b1),
        .m_axis_tdata(m1_tdata), .m_axis_tkeep(m1_tkeep), .m_axis_tdest(m1_tdest),
        .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready), .m_axis_tlast(m1_tlast),
        .busy(busy1), .pkt_count(pkt1), .drop_count(drop1)
    );

    int    n_cmp = 0;
    int    n_err = 0;
    beat_t exp0[$];
    beat_t exp1[$];
    beat_t src1[C1][$];
    bit    first1[C1];
    bit    acc1[C1];
    bit    last_seen1 = 0;
    int    exp_pkt0 = 0, exp_drop0 = 0, exp_pkt1 = 0;
    bit    mon_en0 = 0, mon_en1 = 0, go1 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic beat_t rand_beat(input bit last);
        beat_t b;
        b.data = $urandom;
        b.keep = KW'($urandom);
        b.dest = TW'($urandom);
        b.last = last;
        return b;
    endfunction

    // Output monitors: pop the scoreboard on every master handshake and
    // check that a stalled beat holds still.
    beat_t prev0, prev1;
    bit    stall0 = 0, stall1 = 0;

    always @(negedge clk) begin
        beat_t cur;
        #2;
        cur = {m0_tdata, m0_tkeep, m0_tdest, m0_tlast};
        if (mon_en0) begin
            if (stall0) begin
                check("stall_valid0", 64'(m0_tvalid), 64'd1);
                check("stall_hold0", 64'(cur), 64'(prev0));
            end
            if (m0_tvalid && m0_tready) begin
                n_cmp++;
                if (exp0.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat0: actual=%0h required=none", cur);
                end else begin
                    n_cmp--;
                    check("beat0", 64'(cur), 64'(exp0.pop_front()));
                end
            end
            stall0 = m0_tvalid && !m0_tready;
            prev0  = cur;
        end else begin
            stall0 = 0;
        end
    end

    always @(negedge clk) begin
        beat_t cur;
        #2;
        cur = {m1_tdata, m1_tkeep, m1_tdest, m1_tlast};
        if (mon_en1) begin
            if (stall1) begin
                check("stall_valid1", 64'(m1_tvalid), 64'd1);
                check("stall_hold1", 64'(cur), 64'(prev1));
            end
            if (m1_tvalid && m1_tready) begin
                n_cmp++;
                if (exp1.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat1: actual=%0h required=none", cur);
                end else begin
                    n_cmp--;
                    check("beat1", 64'(cur), 64'(exp1.pop_front()));
                end
            end
            stall1 = m1_tvalid && !m1_tready;
            prev1  = cur;
        end else begin
            stall1 = 0;
        end
    end

    // Round-robin sources: every channel offers its next packet's first beat
    // immediately, so each IDLE cycle sees all non-exhausted channels valid.
    always @(negedge clk) begin
        if (go1) begin
            if (last_seen1) check("idle_after_last1", 64'(busy1), 64'd0);
            for (int c = 0; c < C1; c++) begin
                if (acc1[c]) begin
                    first1[c]    = src1[c][0].last;
                    void'(src1[c].pop_front());
                    s1_tvalid[c] = 1'b0;
                end
                if (src1[c].size() > 0) begin
                    if (!s1_tvalid[c])
                        s1_tvalid[c] = first1[c] ? 1'b1 : ($urandom_range(0, 3) != 0);
                    s1_tdata[c*DW +: DW] = src1[c][0].data;
                    s1_tkeep[c*KW +: KW] = src1[c][0].keep;
                    s1_tdest[c*TW +: TW] = src1[c][0].dest;
                    s1_tlast[c]          = src1[c][0].last;
                end else begin
                    s1_tvalid[c] = 1'b0;
                end
            end
            m1_tready = ($urandom_range(0, 3) != 0);
            #1;
            check("one_ready1", 64'($countones(s1_tready) <= 1), 64'd1);
            last_seen1 = 0;
            for (int c = 0; c < C1; c++) begin
                acc1[c] = s1_tvalid[c] && s1_tready[c];
                if (acc1[c] && s1_tlast[c]) last_seen1 = 1;
            end
        end
    end

    task automatic tick0();
        @(negedge clk);
        m0_tready = ($urandom_range(0, 3) != 0);
    endtask

    // Command one packet on the select-driven instance and feed it in.
    task automatic cmd_packet0(input int ch, input bit drop, input int len, input bit fixed);
        beat_t          pkt[$];
        beat_t          b;
        int             idx, cyc;
        bit             acc;
        logic [C0-1:0]  mask;
        for (int i = 0; i < len; i++) begin
            b = rand_beat(i == len - 1);
            if (fixed) b.data = DW'(32'hA1 + i);
            pkt.push_back(b);
            if (!drop) exp0.push_back(b);
        end
        if (drop) exp_drop0++;
        else      exp_pkt0++;
        cyc = 0;
        while (busy0 !== 1'b0 && cyc < 100) begin
            tick0();
            cyc++;
        end
        check("wait_idle0", 64'(busy0), 64'd0);
        sel0       = 2'(ch);
        sel_valid0 = 1'b1;
        sel_drop0  = drop;
        s0_tvalid[ch]        = 1'b1;
        s0_tdata[ch*DW +: DW] = pkt[0].data;
        s0_tkeep[ch*KW +: KW] = pkt[0].keep;
        s0_tdest[ch*TW +: TW] = pkt[0].dest;
        s0_tlast[ch]          = pkt[0].last;
        #1;
        check("idle_no_ready0", 64'(s0_tready), 64'd0);
        tick0();
        sel_valid0 = 1'b0;
        sel0       = 2'($urandom);
        sel_drop0  = 1'($urandom);
        check("grant0", 64'(busy0), 64'd1);
        mask     = '1;
        mask[ch] = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < len && cyc < 200) begin
            if (!s0_tvalid[ch]) s0_tvalid[ch] = ($urandom_range(0, 3) != 0);
            s0_tdata[ch*DW +: DW] = pkt[idx].data;
            s0_tkeep[ch*KW +: KW] = pkt[idx].keep;
            s0_tdest[ch*TW +: TW] = pkt[idx].dest;
            s0_tlast[ch]          = pkt[idx].last;
            #1;
            check("iso0", 64'(s0_tready & mask), 64'd0);
            if (drop) check("drop_ready0", 64'(s0_tready[ch]), 64'd1);
            acc = s0_tvalid[ch] && s0_tready[ch];
            tick0();
            if (acc) begin
                idx++;
                s0_tvalid[ch] = 1'b0;
            end
            cyc++;
        end
        check("pkt_done0", 64'(idx), 64'(len));
        s0_tvalid[ch] = 1'b0;
        check("idle_after_last0", 64'(busy0), 64'd0);
    endtask

    initial begin
        int t;
        // Round-robin reference: all channels always offer, so packets leave
        // in channel order 0,1,2,3,0,... one round per packet index.
        for (int c = 0; c < C1; c++) first1[c] = 1;
        for (int k = 0; k < NP; k++) begin
            for (int c = 0; c < C1; c++) begin
                int len;
                beat_t b;
                len = $urandom_range(1, 4);
                for (int i = 0; i < len; i++) begin
                    b = rand_beat(i == len - 1);
                    b.dest = TW'(c * 64 + k);
                    src1[c].push_back(b);
                end
            end
        end
        for (int k = 0; k < NP; k++)
            for (int c = 0; c < C1; c++) begin
                int seen;
                seen = 0;
                foreach (src1[c][i]) begin
                    if (seen == k) exp1.push_back(src1[c][i]);
                    if (src1[c][i].last) seen++;
                end
            end
        exp_pkt1 = NP * C1;

        repeat (3) @(negedge clk);
        check("rst_mvalid0", 64'(m0_tvalid), 64'd0);
        check("rst_mdata0", 64'({m0_tdata, m0_tkeep, m0_tdest, m0_tlast}), 64'd0);
        check("rst_busy0", 64'(busy0), 64'd0);
        check("rst_sready0", 64'(s0_tready), 64'd0);
        check("rst_cnt0", 64'({pkt0, drop0}), 64'd0);
        check("rst_mvalid1", 64'(m1_tvalid), 64'd0);
        check("rst_busy1", 64'(busy1), 64'd0);
        check("rst_cnt1", 64'({pkt1, drop1}), 64'd0);
        rst0    = 1'b0;
        rst1    = 1'b0;
        mon_en0 = 1;
        mon_en1 = 1;
        go1     = 1;

        sel0       = 2'd3;
        sel_valid0 = 1'b1;
        repeat (3) begin
            tick0();
            check("sel_out_of_range0", 64'(busy0), 64'd0);
        end
        sel_valid0 = 1'b0;

        cmd_packet0(2, 0, 2, 0);
        cmd_packet0(1, 0, 3, 1);
        check("pkt_after_first0", 64'(s0_tready[0]), 64'd0);
        cmd_packet0(0, 1, 4, 0);
        cmd_packet0(0, 0, 1, 0);
        for (int n = 0; n < 25; n++)
            cmd_packet0($urandom_range(0, C0 - 1), ($urandom_range(0, 3) == 0),
                        $urandom_range(1, 6), 0);

        t = 0;
        while (exp0.size() > 0 && t < 500) begin
            tick0();
            t++;
        end
        check("drain0", 64'(exp0.size()), 64'd0);
        tick0();
        tick0();
        check("pkt_count0", 64'(pkt0), 64'(exp_pkt0));
        check("drop_count0", 64'(drop0), 64'(exp_drop0));

        t = 0;
        while (exp1.size() > 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("drain1", 64'(exp1.size()), 64'd0);
        repeat (2) @(negedge clk);
        check("pkt_count1", 64'(pkt1), 64'(exp_pkt1));
        check("drop_count1", 64'(drop1), 64'd0);
        check("busy_end1", 64'(busy1), 64'd0);

        // Reset while a packet is half through: output is full and stalled.
        mon_en0    = 0;
        m0_tready  = 1'b0;
        sel0       = 2'd0;
        sel_valid0 = 1'b1;
        sel_drop0  = 1'b0;
        s0_tvalid[0]   = 1'b1;
        s0_tdata[0 +: DW] = 32'h0000_0B01;
        s0_tlast[0]    = 1'b0;
        @(negedge clk);
        sel_valid0 = 1'b0;
        @(negedge clk);
        s0_tdata[0 +: DW] = 32'h0000_0B02;
        check("pre_rst_mvalid0", 64'(m0_tvalid), 64'd1);
        check("pre_rst_busy0", 64'(busy0), 64'd1);
        rst0 = 1'b1;
        @(negedge clk);
        check("mid_rst_mvalid0", 64'(m0_tvalid), 64'd0);
        check("mid_rst_busy0", 64'(busy0), 64'd0);
        check("mid_rst_cnt0", 64'({pkt0, drop0}), 64'd0);
        check("mid_rst_sready0", 64'(s0_tready), 64'd0);
        rst0      = 1'b0;
        s0_tvalid = '0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
